// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector with run control (arm, count, target, abort).
// Latency: p_det/match_cnt/done update 1 clock after the completing qualified bit.
// No backpressure: in_valid qualifies bits, and gaps in in_valid are transparent.
module seq_det_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               busy,
   output logic               p_det,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               done,
   output logic               cfg_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;

   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_next;
   logic               is_match;
   logic [CNT_W-1:0]   cnt_inc;
   logic               hit_target;
   logic               len_ok;

   // Next history/fill, match compare over the low len bits, and target test
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
      hist_next  = {hist[MAX_LEN-2:0], in_bit};
      fill_next  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
      is_match   = in_valid && (fill_next >= len_q) &&
                   (((hist_next ^ pat_q) & mask) == '0);
      cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
      hit_target = (tgt_q != '0) && (cnt_inc == tgt_q);
      len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   end

   // Run-control FSM with registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hist      <= '0;
         fill      <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         ovl_q     <= 1'b0;
         tgt_q     <= '0;
         match_cnt <= '0;
         busy      <= 1'b0;
         p_det     <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         p_det   <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     pat_q     <= cfg_pattern;
                     len_q     <= cfg_len;
                     ovl_q     <= cfg_overlap;
                     tgt_q     <= cfg_target;
                     hist      <= '0;
                     fill      <= '0;
                     match_cnt <= '0;
                     state     <= ARMED;
                     busy      <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ARMED: begin
               // Abort wins over a match completing in the same cycle
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (in_valid) begin
                  hist <= hist_next;
                  if (is_match) begin
                     p_det     <= 1'b1;
                     match_cnt <= cnt_inc;
                     // Non-overlap restarts the fill so matched bits are not reused
                     fill      <= ovl_q ? fill_next : '0;
                     if (hit_target) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     fill <= fill_next;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
